// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Handshake and operand/result bundle for the sequential divider.
//   start : request (driven by the requester), sampled only while idle
//   a     : DW-bit dividend, captured on the accepting edge
//   b     : VW-bit divisor, captured on the accepting edge
//   q     : DW-bit quotient (registered)
//   r     : VW-bit remainder (registered)
//   busy  : high while the divider is iterating
//   done  : one-cycle pulse, q/r/dbz valid while it is high
//   dbz   : divide-by-zero flag for the last operation
// Handshake: a request is a cycle with start=1 while the divider is idle;
// it is accepted on that rising edge and never queued. Exactly one done
// pulse follows each accepted request; start seen while busy or done is
// dropped. busy and done are never high together.
// Modports: master = requester, slave = divider.
// ---------------------------------------------------------------------------
interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          busy;
    logic          done;
    logic          dbz;

    modport master (
        output start, a, b,
        input  q, r, busy, done, dbz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, dbz
    );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider: DW-bit dividend / VW-bit divisor, one quotient
// bit per clock.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : seq_divider_if slave (start/a/b in, q/r/busy/done/dbz out)
//   dbg_state : current FSM state (0 IDLE, 1 CALC, 2 DONE)
// Latency: accept at edge E, busy after E..E+DW-1, done after E+DW,
// idle again after E+DW+1. A zero divisor skips straight to DONE with
// q = all ones, r = 0, dbz = 1.
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [VW:0]   rem;       // partial remainder, always < divisor
    logic [DW-1:0] dvd;       // dividend shifts out the top, quotient in the bottom
    logic [VW-1:0] dsr;       // latched divisor
    logic [CW-1:0] cnt;       // iterations completed
    logic [DW-1:0] q_reg;
    logic [VW-1:0] r_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          dbz_reg;

    // One iteration of the restoring step. The shifted value is formed VW+2
    // wide so the top bit of the trial subtraction is a clean sign bit.
    logic [VW+1:0] rem_sh;
    logic [VW+1:0] trial;
    logic [VW:0]   rem_next;
    logic [DW-1:0] dvd_next;
    logic          last_iter;

    always_comb begin
        rem_sh   = {rem, dvd[DW-1]};
        trial    = rem_sh - {2'b00, dsr};
        rem_next = rem_sh[VW:0];
        dvd_next = {dvd[DW-2:0], 1'b0};
        if (!trial[VW+1]) begin
            rem_next    = trial[VW:0];
            dvd_next[0] = 1'b1;
        end
    end

    assign last_iter = (cnt == CW'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.b != '0) begin
                            rem      <= '0;
                            dvd      <= bus.a;
                            dsr      <= bus.b;
                            cnt      <= '0;
                            dbz_reg  <= 1'b0;
                            busy_reg <= 1'b1;
                            state    <= CALC;
                        end else begin
                            // Zero divisor: results are published on the
                            // accepting edge, no iterations.
                            q_reg    <= '1;
                            r_reg    <= '0;
                            dbz_reg  <= 1'b1;
                            done_reg <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        q_reg    <= dvd_next;
                        r_reg    <= rem_next[VW-1:0];
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.q     = q_reg;
    assign bus.r     = r_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.dbz   = dbz_reg;
    assign dbg_state = state;

endmodule
